// File: rtl/md_unit_if.sv
// ============================================================================
// md_unit_if : operand/result bundle between the controller and md_unit
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface md_unit_if;
  logic        start;
  logic [2:0]  mdOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, mdOp, A, B, input busy, hi, lo);
  modport slave  (input start, mdOp, A, B, output busy, hi, lo);
endinterface

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// md_unit  : multi-cycle multiply/divide unit with HI/LO registers
// Revision : 1.0
// ============================================================================
`default_nettype none

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire logic  clk,
  input  wire logic  reset,
  md_unit_if.slave   bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic [2:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;

  logic          is_md;
  logic          is_mul;
  logic          accept;
  logic          finish;
  logic          mthi_wr;
  logic          mtlo_wr;

  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic [31:0]   quot_mag;
  logic [31:0]   rem_mag;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic          res_we;

  assign is_md   = bus.mdOp inside {3'd1, 3'd2, 3'd3, 3'd4};
  assign is_mul  = bus.mdOp inside {3'd1, 3'd2};
  assign mthi_wr = (state == IDLE) && bus.start && (bus.mdOp == 3'd5);
  assign mtlo_wr = (state == IDLE) && bus.start && (bus.mdOp == 3'd6);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && is_md) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (count == CW'(1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Signed divide runs on magnitudes so that 0x80000000 / -1 wraps cleanly.
  assign prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u   = {32'd0, a_q} * {32'd0, b_q};
  assign a_mag    = (op_q == 3'd3 && a_q[31]) ? (32'd0 - a_q) : a_q;
  assign b_mag    = (op_q == 3'd3 && b_q[31]) ? (32'd0 - b_q) : b_q;
  assign quot_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign rem_mag  = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    res_we = 1'b0;
    case (op_q)
      3'd1: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; res_we = 1'b1; end
      3'd2: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; res_we = 1'b1; end
      3'd3: begin
        res_lo = (a_q[31] ^ b_q[31]) ? (32'd0 - quot_mag) : quot_mag;
        res_hi = a_q[31] ? (32'd0 - rem_mag) : rem_mag;
        res_we = (b_q != 32'd0);
      end
      3'd4: begin res_hi = rem_mag; res_lo = quot_mag; res_we = (b_q != 32'd0); end
      default: res_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        count <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        op_q  <= bus.mdOp;
        a_q   <= bus.A;
        b_q   <= bus.B;
      end else if (state == RUN) begin
        count <= count - 1'b1;
      end
      if (finish && res_we) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
      if (mthi_wr) hi_q <= bus.A;
      if (mtlo_wr) lo_q <= bus.A;
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// tb_md_unit : randomized + directed bench for md_unit against a cycle model
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  md_unit_if bus();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Model state: architectural HI/LO, cycles left in flight, pending operation.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_a = 32'd0, m_b = 32'd0;
  logic [2:0]  m_op = 3'd0;
  int          m_left = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l);
    longint p, sa, sb, q, r;
    logic [63:0] u;
    case (op)
      3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); h = p[63:32]; l = p[31:0]; end
      3'd2: begin u = {32'd0, a} * {32'd0, b}; h = u[63:32]; l = u[31:0]; end
      3'd3: if (b != 0) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        q = sa / sb; r = sa % sb;
        l = q[31:0]; h = r[31:0];
      end
      3'd4: if (b != 0) begin l = a / b; h = a % b; end
      default: ;
    endcase
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", {31'd0, bus.busy}, {31'd0, (m_left > 0)});
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
    end
  end

  task automatic step(input logic r, input logic s, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] nh, nl, na, nb;
    logic [2:0]  nop;
    int          nleft;
    reset = r; bus.start = s; bus.mdOp = op; bus.A = a; bus.B = b;
    nh = m_hi; nl = m_lo; na = m_a; nb = m_b; nop = m_op; nleft = m_left;
    if (r) begin
      nh = 0; nl = 0; nleft = 0;
    end else if (m_left > 0) begin
      nleft = m_left - 1;
      if (nleft == 0) result(m_op, m_a, m_b, nh, nl);
    end else if (s) begin
      if (op >= 3'd1 && op <= 3'd4) begin
        nleft = (op <= 3'd2) ? MC : DC;
        nop = op; na = a; nb = b;
      end else if (op == 3'd5) nh = a;
      else if (op == 3'd6) nl = a;
    end
    @(posedge clk);
    m_hi = nh; m_lo = nl; m_a = na; m_b = nb; m_op = nop; m_left = nleft;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
  endtask

  // Accept one op, wait (bounded) for busy to drop, then pin cycles and HI/LO.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cyc, input logic [31:0] eh,
                        input logic [31:0] el);
    int n = 0;
    step(1'b0, 1'b1, op, a, b);
    while (bus.busy === 1'b1 && n < 50) begin
      idle();
      n++;
    end
    check({name, "_cycles"}, n, cyc);
    check({name, "_hi"}, bus.hi, eh);
    check({name, "_lo"}, bus.lo, el);
  endtask

  initial begin
    int n;
    reset = 1'b1; bus.start = 1'b0; bus.mdOp = 3'd0; bus.A = 32'd0; bus.B = 32'd0;
    step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    cmp_en = 1'b1;
    step(1'b1, 1'b1, 3'd1, 32'd9, 32'd9);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    idle();
    check("reset_start_ignored", {31'd0, bus.busy}, 32'd0);

    run_op("mult",  3'd1, 32'hFFFFFFFE, 32'd3, MC, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 3'd2, 32'hFFFFFFFE, 32'd3, MC, 32'h00000002, 32'hFFFFFFFA);
    run_op("div",   3'd3, 32'hFFFFFFF9, 32'd2, DC, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",  3'd4, 32'd7, 32'd2, DC, 32'd1, 32'd3);
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, DC, 32'd0, 32'h80000000);

    step(1'b0, 1'b1, 3'd5, 32'h11, 32'd0);
    step(1'b0, 1'b1, 3'd6, 32'h22, 32'd0);
    run_op("div0", 3'd3, 32'd5, 32'd0, DC, 32'h11, 32'h22);

    // Starts while busy must be dropped, mthi included.
    step(1'b0, 1'b1, 3'd1, 32'd6, 32'd7);
    n = 1;
    idle(); n++;
    step(1'b0, 1'b1, 3'd5, 32'hDEAD, 32'd0); n++;
    idle(); n++;
    step(1'b0, 1'b1, 3'd3, 32'd100, 32'd3); n++;
    while (bus.busy === 1'b1 && n < 50) begin idle(); n++; end
    check("blocked_cycles", n, MC + 1);
    check("blocked_hi", bus.hi, 32'd0);
    check("blocked_lo", bus.lo, 32'd42);
    run_op("restart", 3'd4, 32'd100, 32'd7, DC, 32'd2, 32'd14);

    step(1'b0, 1'b1, 3'd6, 32'h1234, 32'd0);
    check("mtlo_lo", bus.lo, 32'h1234);
    check("mtlo_busy", {31'd0, bus.busy}, 32'd0);

    // Reset in the third busy cycle kills the pending divide.
    step(1'b0, 1'b1, 3'd5, 32'h55, 32'd0);
    step(1'b0, 1'b1, 3'd4, 32'd50, 32'd5);
    idle();
    idle();
    step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    repeat (12) idle();
    check("midrst_nowrite", bus.lo, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 16));
        default: b = $urandom;
      endcase
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0),
           3'($urandom_range(0, 7)), a, b);
    end

    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
